// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: branch predictor FSM states, BTB entry
// layout and the counter value used when a new entry is allocated.
package cpu_types_pkg;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } bp_state_t;

  // The tag field is sized for the smallest table (4 entries: pc[31:4]
  // still fits in 30 bits). Larger tables zero-extend the upper tag bits.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } bp_entry_t;

  localparam logic [1:0] BP_CTR_INIT = 2'b10;

  // Tag of a PC for a table whose index width is idx_w.
  function automatic logic [29:0] bp_tag(input logic [31:0] pc,
                                         input int unsigned idx_w);
    return 30'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating up/down counter step.
//   ctr_i   : current counter value
//   taken_i : branch outcome (1 = count up, 0 = count down)
//   ctr_o   : next counter value, clamped to 0..3
module bp_sat_ctr2 (
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != 2'b11) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != 2'b00) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Dynamic branch predictor and mispredict-recovery controller.
// Predicts direction/target for the IF PC from a direct-mapped BTB with
// 2-bit counters, resolves BEQ/BNE outcomes from MEM, updates the table,
// and on a mispredict flushes ID/EX/MEM and redirects the PC, followed by
// a one-cycle RECOVER state.
//   CLK, nRST                : clock, synchronous active-low reset
//   stall                    : pipeline freeze; blocks update/flush/state
//   if_pc                    : PC to predict
//   pred_taken, pred_target  : combinational prediction
//   res_*                    : resolving branch from MEM
//   flush_ID/EX/MEM, redirect, redirect_pc : mispredict recovery outputs
//   branch_cnt, mispred_cnt  : saturating statistics counters
module branch_pred_ctrl
  import cpu_types_pkg::*;
#(
  parameter  int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        flush_ID,
  output logic        flush_EX,
  output logic        flush_MEM,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  bp_entry_t        tbl_q [ENTRIES];
  bp_state_t        state_q, state_d;
  logic [31:0]      branch_cnt_q, mispred_cnt_q;

  logic [IDX_W-1:0] if_idx, res_idx;
  bp_entry_t        if_ent, res_ent;
  logic             if_hit, res_hit;
  logic             acc, mispredict;
  logic [1:0]       ctr_nxt;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign res_idx = res_pc[IDX_W+1:2];
  assign if_ent  = tbl_q[if_idx];
  assign res_ent = tbl_q[res_idx];
  assign if_hit  = if_ent.valid  && (if_ent.tag  == bp_tag(if_pc,  IDX_W));
  assign res_hit = res_ent.valid && (res_ent.tag == bp_tag(res_pc, IDX_W));

  // Lookup reads the registered table, so a same-cycle update is not seen.
  assign pred_taken  = if_hit && if_ent.ctr[1] && (state_q == NORMAL);
  assign pred_target = pred_taken ? if_ent.target : if_pc + 32'd4;

  assign acc        = res_valid && !stall && (state_q == NORMAL);
  assign mispredict = acc && ((res_pred_taken != res_taken) ||
                              (res_taken && (res_pred_target != res_target)));

  assign flush_ID    = mispredict;
  assign flush_EX    = mispredict;
  assign flush_MEM   = mispredict;
  assign redirect    = mispredict;
  assign redirect_pc = res_taken ? res_target : res_pc + 32'd4;

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  bp_sat_ctr2 u_ctr (
    .ctr_i   (res_ent.ctr),
    .taken_i (res_taken),
    .ctr_o   (ctr_nxt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL:  if (mispredict) state_d = RECOVER;
      RECOVER: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      state_q       <= NORMAL;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      if (acc) begin
        if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
        if (mispredict && (mispred_cnt_q != '1))
          mispred_cnt_q <= mispred_cnt_q + 32'd1;
        if (res_hit) begin
          tbl_q[res_idx].ctr <= ctr_nxt;
          if (res_taken) tbl_q[res_idx].target <= res_target;
        end else if (res_taken) begin
          tbl_q[res_idx] <= '{valid:  1'b1,
                              tag:    bp_tag(res_pc, IDX_W),
                              target: res_target,
                              ctr:    BP_CTR_INIT};
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
module tb_branch_pred_ctrl;

  logic        CLK = 1'b0;
  logic        nRST, stall;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid, res_taken, res_pred_taken;
  logic [31:0] res_pc, res_target, res_pred_target;
  logic        flush_ID, flush_EX, flush_MEM, redirect;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;
  int vid    = 0;

  typedef struct {
    int          id;
    logic        pt;
    logic [31:0] ptgt;
    logic        fl;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];

  branch_pred_ctrl #(.ENTRIES(16)) dut (
    .CLK(CLK), .nRST(nRST), .stall(stall), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input int id, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec %0d %s: got 0x%08h expected 0x%08h", id, nm, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.id, "pred_taken",  32'(pred_taken), 32'(e.pt));
        chk(e.id, "pred_target", pred_target, e.ptgt);
        chk(e.id, "flush_ID",    32'(flush_ID),  32'(e.fl));
        chk(e.id, "flush_EX",    32'(flush_EX),  32'(e.fl));
        chk(e.id, "flush_MEM",   32'(flush_MEM), 32'(e.fl));
        chk(e.id, "redirect",    32'(redirect),  32'(e.fl));
        if (e.fl) chk(e.id, "redirect_pc", redirect_pc, e.rpc);
        chk(e.id, "branch_cnt",  branch_cnt,  e.bc);
        chk(e.id, "mispred_cnt", mispred_cnt, e.mc);
      end
    end
  end

  // Apply one cycle of stimulus and queue the response expected in it.
  task automatic vec(input logic st, input logic rn, input logic [31:0] ipc,
                     input logic rv, input logic [31:0] rpc, input logic rt,
                     input logic [31:0] rtg, input logic rpt,
                     input logic [31:0] rptg,
                     input logic ept, input logic [31:0] eptg,
                     input logic efl, input logic [31:0] erpc,
                     input logic [31:0] ebc, input logic [31:0] emc);
    exp_t e;
    stall = st; nRST = rn; if_pc = ipc;
    res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
    res_pred_taken = rpt; res_pred_target = rptg;
    e.id = vid; e.pt = ept; e.ptgt = eptg; e.fl = efl; e.rpc = erpc;
    e.bc = ebc; e.mc = emc;
    q.push_back(e);
    vid++;
    @(posedge CLK); #1;
  endtask

  initial begin
    nRST = 1'b0; stall = 1'b0; if_pc = '0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    res_pred_taken = 1'b0; res_pred_target = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    //   st rn if_pc  rv res_pc  rt rtgt   rpt rptgt   ept eptgt  efl erpc   bc  mc
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44, 0, 32'h0,   0, 0); // 0 reset state
    vec(0, 1, 32'h40, 1, 32'h40, 1, 32'h80,  0, 32'h44,  0, 32'h44, 1, 32'h80,  0, 0); // 1 taken mispredict, same-idx read
    vec(0, 1, 32'h40, 1, 32'h40, 1, 32'h80,  0, 32'h44,  0, 32'h44, 0, 32'h0,   1, 1); // 2 RECOVER: dropped
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h80, 0, 32'h0,   1, 1); // 3 predicts taken
    vec(0, 1, 32'h40, 1, 32'h40, 1, 32'h80,  1, 32'h80,  1, 32'h80, 0, 32'h0,   1, 1); // 4 correct, ctr 2->3
    vec(0, 1, 32'h40, 1, 32'h40, 1, 32'h80,  1, 32'h80,  1, 32'h80, 0, 32'h0,   2, 1); // 5 back-to-back, ctr stays 3
    vec(0, 1, 32'h40, 1, 32'h40, 0, 32'h80,  1, 32'h80,  1, 32'h80, 1, 32'h44,  3, 1); // 6 not taken, ctr 3->2
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44, 0, 32'h0,   4, 2); // 7 RECOVER
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h80, 0, 32'h0,   4, 2); // 8 ctr=2 still taken
    vec(0, 1, 32'h40, 1, 32'h40, 0, 32'h80,  1, 32'h80,  1, 32'h80, 1, 32'h44,  4, 2); // 9 ctr 2->1
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44, 0, 32'h0,   5, 3); // 10 RECOVER
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44, 0, 32'h0,   5, 3); // 11 ctr=1 not taken
    vec(1, 1, 32'h40, 1, 32'h40, 1, 32'h80,  0, 32'h44,  0, 32'h44, 0, 32'h0,   5, 3); // 12 stalled resolution
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44, 0, 32'h0,   5, 3); // 13 no write under stall
    vec(0, 1, 32'h40, 1, 32'h40, 1, 32'h80,  0, 32'h44,  0, 32'h44, 1, 32'h80,  5, 3); // 14 mispredict, ctr 1->2
    vec(1, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44, 0, 32'h0,   6, 4); // 15 RECOVER held by stall
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44, 0, 32'h0,   6, 4); // 16 still RECOVER
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h80, 0, 32'h0,   6, 4); // 17 NORMAL again
    vec(0, 1, 32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84,  0, 32'h84, 1, 32'h200, 6, 4); // 18 alias allocates idx 0
    vec(0, 1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h84, 0, 32'h0,   7, 5); // 19 RECOVER
    vec(0, 1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h200,0, 32'h0,   7, 5); // 20 alias hits
    vec(0, 1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44, 0, 32'h0,   7, 5); // 21 0x40 evicted
    vec(0, 1, 32'h80, 1, 32'h80, 1, 32'h300, 1, 32'h200, 1, 32'h200,1, 32'h300, 7, 5); // 22 wrong target
    vec(0, 1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h84, 0, 32'h0,   8, 6); // 23 RECOVER
    vec(0, 1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h300,0, 32'h0,   8, 6); // 24 target updated
    vec(0, 1, 32'h44, 1, 32'h44, 0, 32'h100, 0, 32'h48,  0, 32'h48, 0, 32'h0,   8, 6); // 25 miss not taken, correct
    vec(0, 1, 32'h44, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h48, 0, 32'h0,   9, 6); // 26 no allocation
    vec(0, 1, 32'h44, 1, 32'h44, 1, 32'h100, 0, 32'h48,  0, 32'h48, 1, 32'h100, 9, 6); // 27 enter RECOVER
    vec(0, 0, 32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h84, 0, 32'h0,  10, 7); // 28 reset in RECOVER
    vec(0, 1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h84, 0, 32'h0,   0, 0); // 29 table cleared
    vec(0, 1, 32'h80, 1, 32'h80, 1, 32'h300, 0, 32'h84,  0, 32'h84, 1, 32'h300, 0, 0); // 30 NORMAL after reset
    res_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
